// File: rtl/fft_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// fft_ctrl_pkg
// Shared types and default constants for the radix-2 SDF stage sequencer.
//   state_t : sequencer states (IDLE, RUN, DRAIN)
//   tag_t   : per-beat framing tag carried alongside the datapath latency
// ---------------------------------------------------------------------------
package fft_ctrl_pkg;

    localparam int NUM_DEF       = 16;   // lanes per beat
    localparam int DATA_DEF      = 512;  // samples per frame
    localparam int TW_IDX_W_DEF  = 3;    // twiddle index width
    localparam int PIPE_LAT_DEF  = 3;    // accepted beat -> datapath output
    localparam int DRAIN_CYC_DEF = 2;    // in_ready-low cycles after a frame

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    typedef struct packed {
        logic valid;
        logic sof;
        logic eof;
    } tag_t;

endpackage

// File: rtl/fft_tag_pipe.sv
// ---------------------------------------------------------------------------
// fft_tag_pipe
// Fixed-latency shift register for framing tags, so valid/sof/eof line up
// with the butterfly/twiddle datapath output.
//   clk       : clock, rising edge
//   rst       : synchronous active-high reset, empties the pipe
//   in_tag    : tag entering this cycle (valid=0 when no beat accepted)
//   out_tag   : tag that entered PIPE_LAT cycles earlier
//   any_valid : at least one stage holds a valid tag
// ---------------------------------------------------------------------------
module fft_tag_pipe
    import fft_ctrl_pkg::*;
#(
    parameter int PIPE_LAT = PIPE_LAT_DEF
) (
    input  logic clk,
    input  logic rst,
    input  tag_t in_tag,
    output tag_t out_tag,
    output logic any_valid
);

    tag_t                stage_q [PIPE_LAT];
    tag_t                stage_d [PIPE_LAT];
    logic [PIPE_LAT-1:0] valid_vec;

    always_comb begin
        stage_d[0] = in_tag;
        for (int i = 1; i < PIPE_LAT; i++) begin
            stage_d[i] = stage_q[i-1];
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < PIPE_LAT; i++) begin
            if (rst) begin
                stage_q[i] <= '0;
            end else begin
                stage_q[i] <= stage_d[i];
            end
        end
    end

    generate
        for (genvar gi = 0; gi < PIPE_LAT; gi++) begin : g_valid
            assign valid_vec[gi] = stage_q[gi].valid;
        end
    endgenerate

    assign any_valid = |valid_vec;
    assign out_tag   = stage_q[PIPE_LAT-1];

endmodule

// File: rtl/fft_stage_ctrl.sv
// ---------------------------------------------------------------------------
// fft_stage_ctrl
// Frame sequencer for one radix-2 SDF butterfly stage. Accepts beats under
// valid/ready, checks frame framing, drives the stage controls and re-times
// the frame tags to the datapath output.
//   clk         : clock, rising edge
//   rst         : synchronous reset, active-high
//   in_valid    : upstream beat valid
//   in_sof      : first beat of a frame
//   in_ready    : stage can accept a beat
//   dly_en      : delay-line write enable (one cycle after an accepted beat)
//   bf_en       : butterfly path select, follows beat index bit 0
//   tw_idx      : twiddle LUT index, beat index mod 2**TW_IDX_W (holds when idle)
//   out_valid   : datapath output beat valid
//   out_sof     : first output beat of a frame
//   out_eof     : last output beat of a completed frame
//   busy        : sequencer not idle or tags still in flight
//   err_frame   : sticky framing error
//   clr_err     : clears err_frame (a simultaneous new error wins)
//   frames_done : completed frame count, wraps
// ---------------------------------------------------------------------------
module fft_stage_ctrl
    import fft_ctrl_pkg::*;
#(
    parameter int NUM       = NUM_DEF,
    parameter int DATA      = DATA_DEF,
    parameter int COUNT     = DATA / NUM,
    parameter int TW_IDX_W  = TW_IDX_W_DEF,
    parameter int PIPE_LAT  = PIPE_LAT_DEF,
    parameter int DRAIN_CYC = DRAIN_CYC_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    input  logic                in_sof,
    output logic                in_ready,
    output logic                dly_en,
    output logic                bf_en,
    output logic [TW_IDX_W-1:0] tw_idx,
    output logic                out_valid,
    output logic                out_sof,
    output logic                out_eof,
    output logic                busy,
    output logic                err_frame,
    input  logic                clr_err,
    output logic [15:0]         frames_done
);

    localparam int CNT_W = $clog2(COUNT);
    localparam int DRN_W = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(COUNT - 1);
    localparam logic [DRN_W-1:0] DRN_LAST  = DRN_W'(DRAIN_CYC - 1);

    state_t                state_q, state_d;
    logic [CNT_W-1:0]      beat_cnt_q, beat_cnt_d;
    logic [DRN_W-1:0]      drain_cnt_q, drain_cnt_d;
    logic                  dly_en_q, dly_en_d;
    logic                  bf_en_q, bf_en_d;
    logic [TW_IDX_W-1:0]   tw_idx_q, tw_idx_d;
    logic                  err_q, err_d;
    logic [15:0]           frames_q, frames_d;

    logic                  ready_c;
    logic                  acc;
    logic                  tag_acc;     // accepted beat that belongs to a frame
    logic                  set_err;
    logic [CNT_W-1:0]      beat_idx;
    tag_t                  in_tag;
    tag_t                  out_tag;
    logic                  pipe_busy;

    // Gated by rst directly so in_ready reads 0 while reset is held and 1 on
    // the very first cycle after it is released.
    assign ready_c = !rst && (state_q != DRAIN);
    assign acc     = in_valid && ready_c;

    always_comb begin
        state_d     = state_q;
        beat_cnt_d  = beat_cnt_q;
        drain_cnt_d = drain_cnt_q;
        tag_acc     = 1'b0;
        set_err     = 1'b0;
        beat_idx    = '0;
        case (state_q)
            IDLE: begin
                if (acc) begin
                    if (in_sof) begin
                        tag_acc    = 1'b1;
                        beat_cnt_d = CNT_W'(1);
                        state_d    = RUN;
                    end else begin
                        // Orphan beat: dropped without a tag.
                        set_err = 1'b1;
                    end
                end
            end
            RUN: begin
                if (acc) begin
                    tag_acc = 1'b1;
                    if (in_sof) begin
                        // Early restart: current frame abandoned, new one
                        // starts at beat 0 with this beat.
                        set_err    = 1'b1;
                        beat_cnt_d = CNT_W'(1);
                    end else begin
                        beat_idx = beat_cnt_q;
                        if (beat_cnt_q == LAST_BEAT) begin
                            beat_cnt_d  = '0;
                            drain_cnt_d = '0;
                            state_d     = DRAIN;
                        end else begin
                            beat_cnt_d = beat_cnt_q + CNT_W'(1);
                        end
                    end
                end else if (!in_valid) begin
                    // The datapath is free-running, a bubble breaks the frame.
                    set_err    = 1'b1;
                    beat_cnt_d = '0;
                    state_d    = IDLE;
                end
            end
            DRAIN: begin
                if (drain_cnt_q == DRN_LAST) begin
                    state_d = IDLE;
                end else begin
                    drain_cnt_d = drain_cnt_q + DRN_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        dly_en_d = tag_acc;
        bf_en_d  = tag_acc && beat_idx[0];
        tw_idx_d = tag_acc ? beat_idx[TW_IDX_W-1:0] : tw_idx_q;

        in_tag       = '0;
        in_tag.valid = tag_acc;
        in_tag.sof   = tag_acc && (beat_idx == '0);
        in_tag.eof   = tag_acc && (beat_idx == LAST_BEAT);

        err_d = err_q;
        if (set_err) begin
            err_d = 1'b1;
        end else if (clr_err) begin
            err_d = 1'b0;
        end

        frames_d = frames_q;
        if (out_tag.valid && out_tag.eof) begin
            frames_d = frames_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            beat_cnt_q  <= '0;
            drain_cnt_q <= '0;
            dly_en_q    <= 1'b0;
            bf_en_q     <= 1'b0;
            tw_idx_q    <= '0;
            err_q       <= 1'b0;
            frames_q    <= '0;
        end else begin
            state_q     <= state_d;
            beat_cnt_q  <= beat_cnt_d;
            drain_cnt_q <= drain_cnt_d;
            dly_en_q    <= dly_en_d;
            bf_en_q     <= bf_en_d;
            tw_idx_q    <= tw_idx_d;
            err_q       <= err_d;
            frames_q    <= frames_d;
        end
    end

    fft_tag_pipe #(
        .PIPE_LAT (PIPE_LAT)
    ) u_tag_pipe (
        .clk       (clk),
        .rst       (rst),
        .in_tag    (in_tag),
        .out_tag   (out_tag),
        .any_valid (pipe_busy)
    );

    assign in_ready    = ready_c;
    assign dly_en      = dly_en_q;
    assign bf_en       = bf_en_q;
    assign tw_idx      = tw_idx_q;
    assign out_valid   = out_tag.valid;
    assign out_sof     = out_tag.sof;
    assign out_eof     = out_tag.eof;
    assign busy        = (state_q != IDLE) || pipe_busy;
    assign err_frame   = err_q;
    assign frames_done = frames_q;

endmodule

// File: tb/tb_fft_stage_ctrl.sv
// ---------------------------------------------------------------------------
// tb_fft_stage_ctrl
// Directed bench for the SDF stage sequencer. Beats are driven one per cycle;
// each driven beat schedules its expected controls (one cycle after accept)
// and its expected output tag (PIPE_LAT cycles after accept) into per-cycle
// expectation arrays that a negedge checker compares against the outputs.
// ---------------------------------------------------------------------------
module tb_fft_stage_ctrl;
    import fft_ctrl_pkg::*;

    localparam int COUNT = 32;
    localparam int LAT   = 3;
    localparam int DEPTH = 2048;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_sof = 1'b0;
    logic        clr_err = 1'b0;
    logic        in_ready, dly_en, bf_en, out_valid, out_sof, out_eof, busy, err_frame;
    logic [2:0]  tw_idx;
    logic [15:0] frames_done;

    fft_stage_ctrl #(
        .NUM       (16),
        .DATA      (512),
        .TW_IDX_W  (3),
        .PIPE_LAT  (LAT),
        .DRAIN_CYC (2)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_sof      (in_sof),
        .in_ready    (in_ready),
        .dly_en      (dly_en),
        .bf_en       (bf_en),
        .tw_idx      (tw_idx),
        .out_valid   (out_valid),
        .out_sof     (out_sof),
        .out_eof     (out_eof),
        .busy        (busy),
        .err_frame   (err_frame),
        .clr_err     (clr_err),
        .frames_done (frames_done)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    bit chk_en  = 1'b0;

    bit       exp_v   [DEPTH];
    bit       exp_s   [DEPTH];
    bit       exp_e   [DEPTH];
    bit       exp_dly [DEPTH];
    bit       exp_bf  [DEPTH];
    bit [2:0] exp_tw  [DEPTH];

    typedef struct packed {
        logic v;
        logic s;
        logic c;
        logic exp_ready;
        logic exp_err;
    } vec_t;

    vec_t tbl [6];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en && cyc < DEPTH) begin
            check("out_valid", 32'(out_valid), 32'(exp_v[cyc]));
            check("out_sof",   32'(out_sof),   32'(exp_s[cyc]));
            check("out_eof",   32'(out_eof),   32'(exp_e[cyc]));
            check("dly_en",    32'(dly_en),    32'(exp_dly[cyc]));
            check("bf_en",     32'(bf_en),     32'(exp_bf[cyc]));
            if (exp_dly[cyc]) begin
                check("tw_idx", 32'(tw_idx), 32'(exp_tw[cyc]));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_exp_from(input int from);
        for (int i = from; i < DEPTH; i++) begin
            exp_v[i]   = 1'b0;
            exp_s[i]   = 1'b0;
            exp_e[i]   = 1'b0;
            exp_dly[i] = 1'b0;
            exp_bf[i]  = 1'b0;
            exp_tw[i]  = 3'd0;
        end
    endtask

    // Drive one beat with frame index k; it is accepted on the next edge.
    task automatic drive_beat(input int k, input logic sof);
        check("in_ready_beat", 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        in_sof   = sof;
        if (cyc + LAT < DEPTH) begin
            exp_dly[cyc+1]  = 1'b1;
            exp_bf[cyc+1]   = k[0];
            exp_tw[cyc+1]   = k[2:0];
            exp_v[cyc+LAT]  = 1'b1;
            exp_s[cyc+LAT]  = (k == 0);
            exp_e[cyc+LAT]  = (k == COUNT - 1);
        end
        $display("[TB] beat k=%0d sof=%0b cycle=%0d", k, sof, cyc);
        tick();
        in_valid = 1'b0;
        in_sof   = 1'b0;
    endtask

    task automatic full_frame();
        for (int k = 0; k < COUNT; k++) begin
            drive_beat(k, k == 0);
        end
    endtask

    // After the last beat: two cycles of in_ready low, then a frame count.
    task automatic finish_frame(input int exp_frames);
        check("drain_ready0", 32'(in_ready), 32'd0);
        check("drain_busy",   32'(busy),     32'd1);
        tick();
        check("drain_ready1", 32'(in_ready), 32'd0);
        tick();
        check("drain_ready2", 32'(in_ready), 32'd1);
        tick();
        check("frames_done", 32'(frames_done), 32'(exp_frames));
        check("busy_idle",   32'(busy),        32'd0);
    endtask

    initial begin
        // Orphan beat / clr_err sequence: {v, s, c, exp_ready, exp_err}
        tbl[0] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};   // dropped beat sets err
        tbl[1] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};   // sticky
        tbl[2] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};   // clr_err clears
        tbl[3] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1};   // set wins over clear
        tbl[4] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        tbl[5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};

        clear_exp_from(0);

        // Reset state
        rst = 1'b1;
        tick();
        chk_en = 1'b1;
        tick();
        check("rst_in_ready", 32'(in_ready),    32'd0);
        check("rst_busy",     32'(busy),        32'd0);
        check("rst_err",      32'(err_frame),   32'd0);
        check("rst_frames",   32'(frames_done), 32'd0);
        check("rst_tw_idx",   32'(tw_idx),      32'd0);
        rst = 1'b0;
        #1;
        check("ready_after_rst", 32'(in_ready), 32'd1);

        // 1/2: one clean frame, control sequence, drain window
        $display("[TB] test 1: single frame");
        full_frame();
        finish_frame(1);

        // 3: gap at beat 10
        $display("[TB] test 3: gap at beat 10");
        for (int k = 0; k < 10; k++) begin
            drive_beat(k, k == 0);
        end
        tick();
        check("gap_err",     32'(err_frame), 32'd1);
        check("gap_ready",   32'(in_ready),  32'd1);
        check("gap_busy",    32'(busy),      32'd1);
        check("gap_tw_hold", 32'(tw_idx),    32'd1);
        for (int i = 0; i < 4; i++) tick();
        check("gap_frames", 32'(frames_done), 32'd1);
        check("gap_busy_end", 32'(busy), 32'd0);
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        check("gap_clr_err", 32'(err_frame), 32'd0);

        // 4: orphan beats and clr_err priority, table-driven
        $display("[TB] test 4: orphan beats");
        for (int i = 0; i < 6; i++) begin
            check("tbl_ready", 32'(in_ready), 32'(tbl[i].exp_ready));
            in_valid = tbl[i].v;
            in_sof   = tbl[i].s;
            clr_err  = tbl[i].c;
            tick();
            in_valid = 1'b0;
            in_sof   = 1'b0;
            clr_err  = 1'b0;
            check("tbl_err", 32'(err_frame), 32'(tbl[i].exp_err));
            $display("[TB] vec %0d v=%0b c=%0b err=%0b", i, tbl[i].v, tbl[i].c, err_frame);
        end
        check("tbl_frames", 32'(frames_done), 32'd1);

        // 5: reset at beat 20
        $display("[TB] test 5: reset mid-frame");
        for (int k = 0; k < 20; k++) begin
            drive_beat(k, k == 0);
        end
        rst      = 1'b1;
        in_valid = 1'b1;
        clear_exp_from(cyc + 1);
        tick();
        check("mid_rst_ready",  32'(in_ready),    32'd0);
        check("mid_rst_dly",    32'(dly_en),      32'd0);
        check("mid_rst_bf",     32'(bf_en),       32'd0);
        check("mid_rst_tw",     32'(tw_idx),      32'd0);
        check("mid_rst_valid",  32'(out_valid),   32'd0);
        check("mid_rst_sof",    32'(out_sof),     32'd0);
        check("mid_rst_eof",    32'(out_eof),     32'd0);
        check("mid_rst_busy",   32'(busy),        32'd0);
        check("mid_rst_err",    32'(err_frame),   32'd0);
        check("mid_rst_frames", 32'(frames_done), 32'd0);
        rst      = 1'b0;
        in_valid = 1'b0;
        #1;
        full_frame();
        finish_frame(1);

        // 6: sof reasserted at beat 5 of frame 1
        $display("[TB] test 6: early restart");
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        for (int k = 0; k < 5; k++) begin
            drive_beat(k, k == 0);
        end
        check("restart_err_before", 32'(err_frame), 32'd0);
        drive_beat(0, 1'b1);
        check("restart_err", 32'(err_frame), 32'd1);
        for (int k = 1; k < COUNT; k++) begin
            drive_beat(k, 1'b0);
        end
        finish_frame(1);
        check("restart_err_sticky", 32'(err_frame), 32'd1);

        tick();
        tick();
        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
